// File: rtl/fifo_wr_arbiter_if.sv
// Write-request bus shared by the requesters, the arbiter and the shared FIFO.
// A word on lane i transfers in a cycle where req[i] and ack[i] are both high.
// ack[i] is fifo_write steered to the owner, so a requester advances its lane only on ack.
interface fifo_wr_arbiter_if #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic                         fifo_full;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           ack;
    logic                         fifo_write;
    logic [DATA_SIZE-1:0]         fifo_wdata;
    logic                         busy;

    modport master (
        output req, req_data, req_last, fifo_full,
        input  grant, ack, fifo_write, fifo_wdata, busy
    );

    modport slave (
        input  req, req_data, req_last, fifo_full,
        output grant, ack, fifo_write, fifo_wdata, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets one requester at a time burst words into a shared FIFO.
// Bursts end on req_last, on MAX_BURST accepted words, or when the owner drops req.
module fifo_wr_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             reset,
    fifo_wr_arbiter_if.slave bus,
    output logic             state_dbg
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IW-1:0]        owner_q;
    logic [IW-1:0]        last_owner_q;
    logic [CW-1:0]        count_q;

    logic                 lo_hit;
    logic                 hi_hit;
    logic [IW-1:0]        lo_idx;
    logic [IW-1:0]        hi_idx;
    logic [IW-1:0]        next_owner;
    logic                 owner_req;
    logic                 owner_last;
    logic [DATA_SIZE-1:0] owner_data;
    logic                 write_en;
    logic                 burst_done;

    // Round-robin pick: lowest requester above last_owner, else wrap to lowest overall.
    always_comb begin
        lo_hit = 1'b0;
        lo_idx = '0;
        hi_hit = 1'b0;
        hi_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                lo_hit = 1'b1;
                lo_idx = IW'(i);
            end
            if (bus.req[i] && (IW'(i) > last_owner_q)) begin
                hi_hit = 1'b1;
                hi_idx = IW'(i);
            end
        end
        next_owner = hi_hit ? hi_idx : lo_idx;
    end

    // grant_q is zero in IDLE, so the owner lane collapses to zero there.
    always_comb begin
        owner_req  = |(bus.req & grant_q);
        owner_last = |(bus.req_last & grant_q);
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_data = owner_data
                       | (bus.req_data[i*DATA_SIZE +: DATA_SIZE] & {DATA_SIZE{grant_q[i]}});
        end
    end

    assign write_en   = (state_q == BURST) && owner_req && !bus.fifo_full;
    assign burst_done = (state_q == BURST)
                     && (!owner_req || (write_en && (owner_last || (count_q == LAST_COUNT))));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IW'(NUM_REQ - 1);
            count_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lo_hit) begin
                        state_q <= BURST;
                        grant_q <= NUM_REQ'(1) << next_owner;
                        owner_q <= next_owner;
                        count_q <= '0;
                    end
                end
                BURST: begin
                    // A full FIFO leaves everything frozen: no write, no count, no timeout.
                    if (burst_done) begin
                        state_q      <= IDLE;
                        grant_q      <= '0;
                        last_owner_q <= owner_q;
                        count_q      <= '0;
                    end else if (write_en) begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.fifo_write = write_en;
    assign bus.ack        = grant_q & {NUM_REQ{write_en}};
    assign bus.fifo_wdata = owner_data;
    assign bus.busy       = (state_q == BURST);
    assign state_dbg      = state_q;
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 8: bits per data word; matches the shared FIFO word width.
REQ-002 Parameter NUM_REQ, default 4: number of write requesters, range 2..8.
REQ-003 Parameter MAX_BURST, default 8: maximum words accepted per grant, range 1..255.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port req, input, NUM_REQ: bit i high means requester i has a word on its data lane.
REQ-007 Port req_data, input, NUM_REQ*DATA_SIZE: packed lanes; lane i is bits [i*DATA_SIZE +: DATA_SIZE].
REQ-008 Port req_last, input, NUM_REQ: bit i marks the current word of requester i as the final word of its burst.
REQ-009 Port fifo_full, input, 1: full flag from the shared FIFO, registered at the FIFO.
REQ-010 Port grant, output, NUM_REQ: one-hot or zero; registered current owner.
REQ-011 Port ack, output, NUM_REQ: bit i high means requester i's word is written this cycle.
REQ-012 Port fifo_write, output, 1: write strobe to the shared FIFO.
REQ-013 Port fifo_wdata, output, DATA_SIZE: write data to the shared FIFO.
REQ-014 Port busy, output, 1: high while in state BURST.

Function
REQ-015 The block SHALL implement two states: IDLE and BURST.
REQ-016 In IDLE, when any req bit is high, the block SHALL select the first requester with req high, searching round-robin from last_owner+1 modulo NUM_REQ, register its one-hot grant, and enter BURST on the next edge.
REQ-017 In IDLE, grant, ack and fifo_write SHALL be 0.
REQ-018 In BURST with owner g: fifo_write = req[g] & ~fifo_full, combinationally.
REQ-019 In BURST: ack = grant when fifo_write is high, else 0; ack SHALL never have more than one bit set.
REQ-020 fifo_wdata SHALL equal lane g of req_data in BURST, and 0 in IDLE.
REQ-021 A word counter SHALL clear on entry to BURST and increment once per accepted word, i.e. each cycle fifo_write is high.
REQ-022 BURST SHALL end, returning to IDLE on the next edge with last_owner set to g and grant cleared, when either (a) an accepted word has req_last[g]=1 or the counter reaches MAX_BURST on that word, or (b) req[g]=0 in a cycle.
REQ-023 When fifo_full=1 in BURST, the block SHALL hold the grant, counter and state with no ack, and SHALL NOT time out.
REQ-024 Requests from non-owners during BURST SHALL be ignored; there is no preemption.
REQ-025 Latency: req[i] rising in IDLE at edge N gives grant at edge N+1; the first write occurs in the cycle after edge N+1 if the FIFO is not full.
REQ-026 Each burst end costs exactly one IDLE arbitration cycle before the next grant.
REQ-027 Round-robin SHALL guarantee that a continuously requesting requester is granted within NUM_REQ-1 other grants.

Reset
REQ-028 While reset is high: state IDLE, grant 0, counter 0, last_owner NUM_REQ-1 (requester 0 has highest priority first), ack 0, fifo_write 0, fifo_wdata 0, busy 0.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately; no partial-burst state survives.

Verification
REQ-030 Reset, then req=4'b0001 with 3 words, req_last on the 3rd -> grant=0001 one cycle later; 3 acks and 3 fifo_write pulses with lane-0 data; then IDLE, busy=0.
REQ-031 req=4'b1111 held, req_last always 0, MAX_BURST=8 -> grants in order 0001, 0010, 0100, 1000, 0001; each burst exactly 8 writes; one idle cycle between bursts.
REQ-032 Requester 2 granted with fifo_full=1 for 5 cycles mid-burst -> fifo_write=0 and ack=0 for those 5 cycles; grant stays 0100; the burst resumes with the word count unchanged.
REQ-033 Requester 1 drops req after 2 words of an intended 6 -> burst ends, last_owner=1, next grant goes to requester 2 if requesting, else 3, else 0.
REQ-034 Reset pulsed during a burst of requester 3 after 4 words -> grant=0 and fifo_write=0 asynchronously; with req=4'b1001 after release, the next grant is 0001.
REQ-035 Every cycle the bench SHALL check: ack is zero or one-hot, ack equals grant&{NUM_REQ{fifo_write}}, and fifo_write=0 whenever fifo_full=1.
